// File: rtl/z_arith_pkg.sv
// Shared arithmetic definitions for the pipelined carry-select adder.
package z_arith_pkg;

    localparam int unsigned ARITH_WIDTH = 16;
    localparam int unsigned ARITH_BLOCK = 4;
    localparam int unsigned STAGES      = ARITH_WIDTH / ARITH_BLOCK;

    // Operand width must split evenly into carry-select groups.
    localparam bit SPLIT_OK = (ARITH_WIDTH % ARITH_BLOCK) == 0;

    // Payload carried from one pipeline stage to the next.
    typedef struct packed {
        logic [ARITH_WIDTH-1:0] sum_lo;
        logic                   carry;
        logic [ARITH_WIDTH-1:0] a_hi;
        logic [ARITH_WIDTH-1:0] b_hi;
    } stage_t;

endpackage

// File: rtl/z_csa_bit.sv
// One bit of a carry-select group: computes both ripple chains side by side.
module z_csa_bit (
    input  logic a,
    input  logic b,
    input  logic c0,
    input  logic c1,
    output logic s0,
    output logic co0,
    output logic s1,
    output logic co1
);

    logic p;

    // Full-adder pair sharing the propagate term.
    always_comb begin
        p   = a ^ b;
        s0  = p ^ c0;
        co0 = (a & b) | (c0 & p);
        s1  = p ^ c1;
        co1 = (a & b) | (c1 & p);
    end

endmodule

// File: rtl/z_csa_block.sv
// BLOCK-bit combinational carry-select group: dual ripple sums muxed by c_sel.
module z_csa_block #(
    parameter int unsigned BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             c_sel,
    output logic [BLOCK-1:0] s,
    output logic             c
);

    logic [BLOCK:0]   chain0;
    logic [BLOCK:0]   chain1;
    logic [BLOCK-1:0] s0;
    logic [BLOCK-1:0] s1;

    assign chain0[0] = 1'b0;
    assign chain1[0] = 1'b1;

    for (genvar i = 0; i < BLOCK; i++) begin : g_bit
        z_csa_bit u_bit (
            .a   (a[i]),
            .b   (b[i]),
            .c0  (chain0[i]),
            .c1  (chain1[i]),
            .s0  (s0[i]),
            .co0 (chain0[i+1]),
            .s1  (s1[i]),
            .co1 (chain1[i+1])
        );
    end

    // Late-arriving carry only drives the final select.
    always_comb begin
        s = c_sel ? s1 : s0;
        c = c_sel ? chain1[BLOCK] : chain0[BLOCK];
    end

endmodule

// File: rtl/z_csa_pipe_adder.sv
// Pipelined carry-select adder: one BLOCK-bit group resolved per stage,
// valid/ready stream with whole-pipeline stall on output backpressure.
module z_csa_pipe_adder
    import z_arith_pkg::*;
#(
    parameter int unsigned WIDTH = ARITH_WIDTH,
    parameter int unsigned BLOCK = ARITH_BLOCK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    if (!SPLIT_OK || WIDTH != ARITH_WIDTH || BLOCK != ARITH_BLOCK) begin : g_bad_cfg
        $error("z_csa_pipe_adder: WIDTH/BLOCK must match z_arith_pkg and divide evenly");
    end

    stage_t            stg_q   [STAGES];
    logic [STAGES-1:0] vld_q;
    stage_t            grp_in  [STAGES];
    stage_t            grp_nxt [STAGES];
    logic [BLOCK-1:0]  s_grp   [STAGES];
    logic              c_grp   [STAGES];
    logic              stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        z_csa_block #(.BLOCK(BLOCK)) u_blk (
            .a     (grp_in[k].a_hi[k*BLOCK +: BLOCK]),
            .b     (grp_in[k].b_hi[k*BLOCK +: BLOCK]),
            .c_sel (grp_in[k].carry),
            .s     (s_grp[k]),
            .c     (c_grp[k])
        );
    end

    // Group k reads the fresh operands (k=0) or the previous stage register.
    always_comb begin
        grp_in[0].sum_lo = '0;
        grp_in[0].carry  = c_in;
        grp_in[0].a_hi   = a;
        grp_in[0].b_hi   = b;
        for (int k = 1; k < STAGES; k++) begin
            grp_in[k] = stg_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            grp_nxt[k]                            = grp_in[k];
            grp_nxt[k].sum_lo[k*BLOCK +: BLOCK]   = s_grp[k];
            grp_nxt[k].carry                      = c_grp[k];
        end
    end

    // Backpressure freezes every stage; bubbles are not squeezed out.
    always_comb begin
        stall    = vld_q[STAGES-1] & ~out_ready;
        in_ready = ~stall;
    end

    // Stage registers: advance together unless stalled; payload moves with valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                stg_q[k] <= '0;
            end
        end else if (!stall) begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                stg_q[0] <= grp_nxt[0];
            end
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) begin
                    stg_q[k] <= grp_nxt[k];
                end
            end
        end
    end

    // Results come straight off the last stage; overflow from the MSB bits.
    always_comb begin
        out_valid = vld_q[STAGES-1];
        sum       = stg_q[STAGES-1].sum_lo;
        c_out     = stg_q[STAGES-1].carry;
        ovf       = (stg_q[STAGES-1].a_hi[WIDTH-1] == stg_q[STAGES-1].b_hi[WIDTH-1]) &&
                    (stg_q[STAGES-1].sum_lo[WIDTH-1] != stg_q[STAGES-1].a_hi[WIDTH-1]);
    end

endmodule
